// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB SPI register interface: register
// addresses, write masks, status bit positions and SPI mode encodings.
package apb_spi_pkg;

  // Register indices (PADDR[2:0])
  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd4;
  localparam logic [2:0] ADDR_FSR = 3'd5;

  // Reset value and writable-bit masks
  localparam logic [7:0] CR1_RST  = 8'h04;
  // Writable CR2 bits: 7..3, 1, 0
  localparam logic [7:0] CR2_MASK = 8'hFB;
  localparam logic [7:0] BR_MASK  = 8'h77;

  // CR1 / CR2 bit positions
  localparam int unsigned CR1_SPE   = 6;
  localparam int unsigned CR2_SPIE  = 7;
  localparam int unsigned CR2_SPTIE = 6;
  localparam int unsigned CR2_ERRIE = 5;

  // SR bit positions
  localparam int unsigned SR_RXNE  = 7;
  localparam int unsigned SR_RXOVF = 6;
  localparam int unsigned SR_TXE   = 5;
  localparam int unsigned SR_TXF   = 4;
  localparam int unsigned SR_RXF   = 3;
  localparam int unsigned SR_TXOVF = 2;

  // SPI mode encodings
  typedef enum logic [1:0] {
    SPI_RUN  = 2'b00,
    SPI_WAIT = 2'b01,
    SPI_STOP = 2'b10
  } spi_mode_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with a zero-latency head.
// Ports: clk, rst (sync active-high), flush (empties the FIFO),
//        push/push_data, pop, head (valid when !empty), full, empty, count.
// A push while full is accepted when a pop happens in the same cycle.
module spi_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push_c;
  logic              do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop_c  = pop & ~empty;
  // The pop frees the slot first, so a full FIFO can still take a push
  assign do_push_c = push & (~full | do_pop_c);
  assign head      = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_c && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_spi_fifo_regif.sv
// APB slave register interface for the SPI master with TX/RX FIFOs.
// Ports: PCLK/PRESET (sync active-high), APB slave (PADDR, PSEL, PENABLE,
//        PWRITE, PWDATA, PRDATA, PREADY, PSLVERR), ss from the SPI core,
//        TX stream (tx_data/tx_valid/tx_ready), RX push (rx_data/rx_valid),
//        CR1/BR configuration outputs, spi_mode and spi_interrupt_request.
// Optional build macro APB_SPI_RX_WAIT_EN: a DR read on an empty RX FIFO
// stalls until a frame arrives or 16 cycles elapse; otherwise it errors
// immediately.
module apb_spi_fifo_regif
  import apb_spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ss,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              spi_interrupt_request
);

  logic [7:0]        cr1_q;
  logic [7:0]        cr2_q;
  logic [7:0]        br_q;
  logic              rxovf_q;
  logic              txovf_q;
  logic              spe_d_q;
  logic              irq_q;
  spi_mode_e         mode_q;
  spi_mode_e         mode_n;

  logic [DATA_W-1:0] rx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;

  logic [2:0]        idx_c;
  logic              access_c;
  logic              addr_ok_c;
  logic              is_dr_c;
  logic              dr_rd_acc_c;
  logic              stall_c;
  logic              pready_c;
  logic              wr_c;
  logic              dr_wr_c;
  logic              fsr_wr_c;
  logic              sr_wr_c;
  logic              tx_pop_c;
  logic              tx_push_c;
  logic              tx_ovf_c;
  logic              rx_push_c;
  logic              rx_pop_c;
  logic              rx_ovf_c;
  logic              flush_c;
  logic              spe_c;
  logic [7:0]        sr_c;
  logic [31:0]       rd_word_c;

  // Address decode and APB handshake
  assign idx_c       = PADDR[2:0];
  assign access_c    = PSEL & PENABLE & ~PRESET;
  assign addr_ok_c   = ((PADDR >> 3) == '0) && (idx_c <= ADDR_FSR);
  assign is_dr_c     = addr_ok_c & (idx_c == ADDR_DR);
  assign dr_rd_acc_c = access_c & ~PWRITE & is_dr_c;

`ifdef APB_SPI_RX_WAIT_EN
  logic [4:0] to_cnt_q;

  // Hold an empty-FIFO DR read until data arrives or the timeout expires
  assign stall_c = dr_rd_acc_c & rx_empty & (to_cnt_q != 5'd16);

  always_ff @(posedge PCLK) begin
    if (PRESET || !PSEL || pready_c) to_cnt_q <= '0;
    else if (stall_c)                to_cnt_q <= to_cnt_q + 5'd1;
  end
`else
  assign stall_c = 1'b0;
`endif

  assign pready_c = access_c & ~stall_c;
  assign wr_c     = pready_c & PWRITE & addr_ok_c;
  assign dr_wr_c  = wr_c & (idx_c == ADDR_DR);
  assign fsr_wr_c = wr_c & (idx_c == ADDR_FSR);
  assign sr_wr_c  = wr_c & (idx_c == ADDR_SR);

  // FIFO traffic; a pop in the same cycle makes room for a push
  assign tx_pop_c  = tx_valid & tx_ready;
  assign tx_ovf_c  = dr_wr_c & tx_full & ~tx_pop_c;
  assign tx_push_c = dr_wr_c & ~tx_ovf_c;
  assign rx_pop_c  = pready_c & dr_rd_acc_c & ~rx_empty;
  assign rx_push_c = rx_valid & (mode_q != SPI_STOP);
  assign rx_ovf_c  = rx_push_c & rx_full & ~rx_pop_c;

  // Flush on the edge after SPE is cleared, together with the STOP entry
  assign spe_c   = cr1_q[CR1_SPE];
  assign flush_c = spe_d_q & ~spe_c;

  assign PREADY  = pready_c;
  assign PSLVERR = pready_c & (~addr_ok_c | fsr_wr_c | tx_ovf_c |
                               (dr_rd_acc_c & rx_empty));
  assign PRDATA  = DATA_W'(rd_word_c);

  // Status register image
  always_comb begin
    sr_c           = '0;
    sr_c[SR_RXNE]  = ~rx_empty;
    sr_c[SR_RXOVF] = rxovf_q;
    sr_c[SR_TXE]   = tx_empty;
    sr_c[SR_TXF]   = tx_full;
    sr_c[SR_RXF]   = rx_full;
    sr_c[SR_TXOVF] = txovf_q;
  end

  // Read mux; error cases and idle phase return zero
  always_comb begin
    rd_word_c = '0;
    if (access_c && addr_ok_c) begin
      unique case (idx_c)
        ADDR_CR1: rd_word_c = 32'(cr1_q);
        ADDR_CR2: rd_word_c = 32'(cr2_q);
        ADDR_BR:  rd_word_c = 32'(br_q);
        ADDR_SR:  rd_word_c = 32'(sr_c);
        ADDR_DR:  if (!rx_empty) rd_word_c = 32'(rx_head);
        ADDR_FSR: rd_word_c = 32'(tx_cnt) | (32'(rx_cnt) << 8);
        default:  rd_word_c = '0;
      endcase
    end
  end

  // Control registers and sticky flags; a new set beats a W1C clear
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cr1_q   <= CR1_RST;
      cr2_q   <= '0;
      br_q    <= '0;
      rxovf_q <= 1'b0;
      txovf_q <= 1'b0;
      spe_d_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_c && idx_c == ADDR_CR1) cr1_q <= PWDATA[7:0];
      if (wr_c && idx_c == ADDR_CR2) cr2_q <= PWDATA[7:0] & CR2_MASK;
      if (wr_c && idx_c == ADDR_BR)  br_q  <= PWDATA[7:0] & BR_MASK;
      rxovf_q <= (rxovf_q & ~(sr_wr_c & PWDATA[SR_RXOVF])) | rx_ovf_c;
      txovf_q <= (txovf_q & ~(sr_wr_c & PWDATA[SR_TXOVF])) | tx_ovf_c;
      spe_d_q <= spe_c;
      irq_q   <= (cr2_q[CR2_SPIE]  & ~rx_empty) |
                 (cr2_q[CR2_SPTIE] & tx_empty)  |
                 (cr2_q[CR2_ERRIE] & (rxovf_q | txovf_q));
    end
  end

  // Mode FSM state register
  always_ff @(posedge PCLK) begin
    if (PRESET) mode_q <= SPI_STOP;
    else        mode_q <= mode_n;
  end

  // Mode FSM next state
  always_comb begin
    mode_n = mode_q;
    if (!spe_c) begin
      mode_n = SPI_STOP;
    end else begin
      unique case (mode_q)
        SPI_STOP: if (!ss) mode_n = SPI_RUN;
        SPI_RUN:  if (ss)  mode_n = SPI_WAIT;
        SPI_WAIT: if (!ss) mode_n = SPI_RUN;
        default:  mode_n = SPI_STOP;
      endcase
    end
  end

  spi_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_tx_fifo (
    .clk      (PCLK),
    .rst      (PRESET),
    .flush    (flush_c),
    .push     (tx_push_c),
    .push_data(PWDATA),
    .pop      (tx_pop_c),
    .head     (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_cnt)
  );

  spi_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_rx_fifo (
    .clk      (PCLK),
    .rst      (PRESET),
    .flush    (flush_c),
    .push     (rx_push_c),
    .push_data(rx_data),
    .pop      (rx_pop_c),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_cnt)
  );

  assign tx_valid              = ~tx_empty;
  assign mstr                  = cr1_q[4];
  assign cpol                  = cr1_q[3];
  assign cpha                  = cr1_q[2];
  assign lsbfe                 = cr1_q[1];
  assign spiswai               = cr1_q[0];
  assign sppr                  = br_q[6:4];
  assign spr                   = br_q[2:0];
  assign spi_mode              = mode_q;
  assign spi_interrupt_request = irq_q;

endmodule
